idp_sequencer: RTL and testbench

//  Control sequencer driving the integer datapath's control-word inputs.

---
 rtl/idp_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_idp_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idp_sequencer.sv
// ---------------------------------------------------------------------------
// idp_sequencer
//   Control sequencer for the integer datapath. Takes 16-bit instruction
//   words over a valid/ready handshake and decodes them. Each instruction
//   produces one registered control word, held for exactly one EXEC cycle.
//   LDI/ADDI take a second word, which becomes the immediate. The sequencer
//   latches the datapath C/N/Z flags at the end of every EXEC cycle.
//
//   Optional feature macro: IDPSEQ_RETIRE_CNT_EN adds a 16-bit retire
//   counter output, retire_cnt. The counter increments once per EXEC cycle
//   and wraps from 16'hFFFF to 0.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   instr_valid/ready   handshake; instr = {op, W, R, S, reserved[2:0]}
//   W_En, W_Adr         register-file write enable / address
//   R_Adr, S_Adr        read-port addresses
//   S_Sel, DS           S-input select (1 = DS) and immediate data
//   ALU_OP              ALU operation code
//   C, N, Z             datapath flags, valid during EXEC
//   flag_c/n/z          architectural flag registers
//   halted              high from the cycle after HALT is accepted
//   retire_cnt          (IDPSEQ_RETIRE_CNT_EN only) EXEC-cycle count
// ---------------------------------------------------------------------------
module idp_sequencer #(
    parameter logic [3:0] ALU_PASS_S = 4'h1,
    parameter logic [3:0] ALU_ADD    = 4'h2,
    parameter logic [3:0] ALU_SUB    = 4'h3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        W_En,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        S_Sel,
    output logic [15:0] DS,
    output logic [3:0]  ALU_OP,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        flag_c,
    output logic        flag_n,
    output logic        flag_z,
    output logic        halted
`ifdef IDPSEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        ready_r, halted_r;
    logic [3:0]  op_r;
    logic [2:0]  w_r, r_r, s_r;
    logic        w_en_r, s_sel_r;
    logic [2:0]  w_adr_r, r_adr_r, s_adr_r;
    logic [15:0] ds_r;
    logic [3:0]  alu_op_r;
    logic        flag_c_r, flag_n_r, flag_z_r;

    logic        transfer_s;
    logic [3:0]  src_op_s;
    logic [2:0]  src_w_s, src_r_s, src_s_s;
    logic        w_en_s, s_sel_s;
    logic [2:0]  w_adr_s, r_adr_s, s_adr_s;
    logic [15:0] ds_s;
    logic [3:0]  alu_op_s;

    // Next-state and next control word; the word is built in the cycle
    // before EXEC so that it can be registered into EXEC.
    always_comb begin
        state_s    = state_r;
        w_en_s     = 1'b0;
        s_sel_s    = 1'b0;
        w_adr_s    = 3'd0;
        r_adr_s    = 3'd0;
        s_adr_s    = 3'd0;
        ds_s       = 16'h0000;
        alu_op_s   = 4'h0;
        transfer_s = instr_valid & ready_r;
        // In IMM the current word is the immediate. Opcode and fields
        // therefore come from the latched first word.
        if (state_r == ST_IMM) begin
            src_op_s = op_r;
            src_w_s  = w_r;
            src_r_s  = r_r;
            src_s_s  = s_r;
        end else begin
            src_op_s = instr[15:12];
            src_w_s  = instr[11:9];
            src_r_s  = instr[8:6];
            src_s_s  = instr[5:3];
        end

        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    if (src_op_s == 4'hF) begin
                        state_s = ST_HALT;
                    end else if ((src_op_s == 4'hC) || (src_op_s == 4'hD)) begin
                        state_s = ST_IMM;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_IMM: begin
                if (transfer_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IMM;
                end
            end
            ST_EXEC: state_s = ST_IDLE;
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_IDLE;
        endcase

        if (state_s == ST_EXEC) begin
            w_adr_s = src_w_s;
            r_adr_s = src_r_s;
            s_adr_s = src_s_s;
            case (src_op_s)
                4'hC: begin
                    alu_op_s = ALU_PASS_S;
                    s_sel_s  = 1'b1;
                    ds_s     = instr;
                    w_en_s   = 1'b1;
                end
                4'hD: begin
                    alu_op_s = ALU_ADD;
                    s_sel_s  = 1'b1;
                    ds_s     = instr;
                    w_en_s   = 1'b1;
                end
                4'hE: begin
                    alu_op_s = ALU_SUB;
                    w_en_s   = 1'b0;
                end
                4'hF: begin
                    alu_op_s = 4'h0;
                    w_en_s   = 1'b0;
                end
                default: begin
                    alu_op_s = src_op_s;
                    w_en_s   = 1'b1;
                end
            endcase
        end else begin
            w_en_s  = 1'b0;
            s_sel_s = 1'b0;
        end
    end

    // State, handshake, control-word and first-word field registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b1;
            halted_r <= 1'b0;
            op_r     <= 4'h0;
            w_r      <= 3'd0;
            r_r      <= 3'd0;
            s_r      <= 3'd0;
            w_en_r   <= 1'b0;
            s_sel_r  <= 1'b0;
            w_adr_r  <= 3'd0;
            r_adr_r  <= 3'd0;
            s_adr_r  <= 3'd0;
            ds_r     <= 16'h0000;
            alu_op_r <= 4'h0;
        end else begin
            state_r  <= state_s;
            ready_r  <= (state_s == ST_IDLE) || (state_s == ST_IMM);
            halted_r <= (state_s == ST_HALT);
            if ((state_r == ST_IDLE) && transfer_s) begin
                op_r <= instr[15:12];
                w_r  <= instr[11:9];
                r_r  <= instr[8:6];
                s_r  <= instr[5:3];
            end else begin
                op_r <= op_r;
                w_r  <= w_r;
                r_r  <= r_r;
                s_r  <= s_r;
            end
            w_en_r   <= w_en_s;
            s_sel_r  <= s_sel_s;
            w_adr_r  <= w_adr_s;
            r_adr_r  <= r_adr_s;
            s_adr_r  <= s_adr_s;
            ds_r     <= ds_s;
            alu_op_r <= alu_op_s;
        end
    end

    // Architectural flags: captured at the end of every EXEC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_c_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            flag_c_r <= C;
            flag_n_r <= N;
            flag_z_r <= Z;
        end else begin
            flag_c_r <= flag_c_r;
            flag_n_r <= flag_n_r;
            flag_z_r <= flag_z_r;
        end
    end

`ifdef IDPSEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt_r;

    // Retire counter: one count per EXEC cycle, natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_r <= 16'h0000;
        end else if (state_r == ST_EXEC) begin
            retire_cnt_r <= retire_cnt_r + 16'h0001;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;
`endif

    assign instr_ready = ready_r;
    assign halted      = halted_r;
    assign W_En        = w_en_r;
    assign W_Adr       = w_adr_r;
    assign R_Adr       = r_adr_r;
    assign S_Adr       = s_adr_r;
    assign S_Sel       = s_sel_r;
    assign DS          = ds_r;
    assign ALU_OP      = alu_op_r;
    assign flag_c      = flag_c_r;
    assign flag_n      = flag_n_r;
    assign flag_z      = flag_z_r;

endmodule

// File: tb/tb_idp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_idp_sequencer
//   Self-checking bench for idp_sequencer. Each scenario task pushes the
//   expected control word for an instruction onto a queue. The monitor pops
//   one entry per EXEC cycle and compares it with the DUT outputs. Scenario
//   tasks also check handshake, flags and halt behaviour inline.
// ---------------------------------------------------------------------------
module tb_idp_sequencer;

    typedef struct packed {
        logic        w_en;
        logic [2:0]  w_adr;
        logic [2:0]  r_adr;
        logic [2:0]  s_adr;
        logic        s_sel;
        logic [15:0] ds;
        logic [3:0]  alu_op;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic        W_En;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        S_Sel;
    logic [15:0] DS;
    logic [3:0]  ALU_OP;
    logic        C = 1'b0, N = 1'b0, Z = 1'b0;
    logic        flag_c, flag_n, flag_z;
    logic        halted;
`ifdef IDPSEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    idp_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .W_En        (W_En),
        .W_Adr       (W_Adr),
        .R_Adr       (R_Adr),
        .S_Adr       (S_Adr),
        .S_Sel       (S_Sel),
        .DS          (DS),
        .ALU_OP      (ALU_OP),
        .C           (C),
        .N           (N),
        .Z           (Z),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .halted      (halted)
`ifdef IDPSEQ_RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: an EXEC cycle shows as ready low while not halted.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (reset === 1'b0 && instr_ready === 1'b0 && halted === 1'b0) begin
            got = {W_En, W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_exec got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL exec_word got=%h required=%h", got, want);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Waits (bounded) for ready, then presents one word for one cycle.
    task automatic send(input logic [15:0] word);
        int n = 0;
        @(posedge clk); #1;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout ready=%b required=1", instr_ready);
        end
        instr_valid = 1'b1;
        instr = word;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'h0000;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({instr_ready, W_En, S_Sel, DS, ALU_OP, W_Adr, R_Adr, S_Adr, halted} !==
            {1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%b_%b_%b_%h_%h halted=%b required ready=1 rest=0",
                     instr_ready, W_En, S_Sel, DS, ALU_OP, halted);
        end
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000", {flag_c, flag_n, flag_z});
        end
    endtask

    task automatic test_alu();
        logic [2:0] w, r, s, res;
        exp_q.push_back('{1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 4'h2});
        send(16'h2298);
        checks++;
        if (instr_ready !== 1'b0 || W_En !== 1'b1 || ALU_OP !== 4'h2) begin
            errors++;
            $display("FAIL t1_exec ready=%b wen=%b op=%h required ready=0 wen=1 op=2",
                     instr_ready, W_En, ALU_OP);
        end
        // Every plain ALU opcode, random fields and reserved bits, back to back.
        for (int i = 0; i < 12; i++) begin
            w   = 3'($urandom_range(7, 0));
            r   = 3'($urandom_range(7, 0));
            s   = 3'($urandom_range(7, 0));
            res = 3'($urandom_range(7, 0));
            exp_q.push_back('{1'b1, w, r, s, 1'b0, 16'h0000, 4'(i)});
            send({4'(i), w, r, s, res});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL alu_drain pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_ldi();
        send(16'hC800);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (instr_ready !== 1'b1 || W_En !== 1'b0) begin
                errors++;
                $display("FAIL ldi_wait ready=%b wen=%b required ready=1 wen=0", instr_ready, W_En);
            end
        end
        exp_q.push_back('{1'b1, 3'd4, 3'd0, 3'd0, 1'b1, 16'hBEEF, 4'h1});
        send(16'hBEEF);
        checks++;
        if (DS !== 16'hBEEF || S_Sel !== 1'b1) begin
            errors++;
            $display("FAIL ldi_exec ds=%h ssel=%b required ds=beef ssel=1", DS, S_Sel);
        end
        @(posedge clk); #1;
        checks++;
        if (DS !== 16'h0000 || S_Sel !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ldi_after ds=%h ssel=%b pending=%0d required 0", DS, S_Sel, exp_q.size());
        end
    endtask

    task automatic test_addi();
        // W/R/S come from the first word; the second word's bits are data only.
        exp_q.push_back('{1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 16'h1234, 4'h2});
        send(16'hD2C0);
        send(16'h1234);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL addi_drain pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_flags();
        C = 1'b1; N = 1'b0; Z = 1'b1;
        exp_q.push_back('{1'b0, 3'd0, 3'd3, 3'd1, 1'b0, 16'h0000, 4'h3});
        send(16'hE0C8);
        checks++;
        if (W_En !== 1'b0) begin
            errors++;
            $display("FAIL cmp_wen got=%b required=0", W_En);
        end
        // Flags must follow C/N/Z only through EXEC, not while idle.
        @(posedge clk); #1;
        C = 1'b0; N = 1'b1; Z = 1'b0;
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b101) begin
            errors++;
            $display("FAIL cmp_flags got=%b required=101", {flag_c, flag_n, flag_z});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b101) begin
            errors++;
            $display("FAIL flags_hold got=%b required=101", {flag_c, flag_n, flag_z});
        end
        exp_q.push_back('{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 4'h0});
        send(16'h0000);
        @(posedge clk); #1;
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b010) begin
            errors++;
            $display("FAIL alu_flags got=%b required=010", {flag_c, flag_n, flag_z});
        end
        C = 1'b0; N = 1'b0; Z = 1'b0;
    endtask

    task automatic test_halt();
        send(16'hF000);
        checks++;
        if (halted !== 1'b1 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter halted=%b ready=%b required halted=1 ready=0", halted, instr_ready);
        end
        instr_valid = 1'b1;
        instr = 16'h2298;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (W_En !== 1'b0 || halted !== 1'b1 || instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold wen=%b halted=%b ready=%b required 0/1/0",
                         W_En, halted, instr_ready);
            end
        end
        instr_valid = 1'b0;
        do_reset();
        checks++;
        if (halted !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL halt_reset halted=%b ready=%b required halted=0 ready=1", halted, instr_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        send(16'hD2C0);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL imm_ready got=%b required=1", instr_ready);
        end
        do_reset();
        checks++;
        if (W_En !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset wen=%b ready=%b required wen=0 ready=1", W_En, instr_ready);
        end
        // This word would be the immediate if the pending ADDI survived.
        exp_q.push_back('{1'b1, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 4'h1});
        send(16'h1A50);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midop_drain pending=%0d required=0", exp_q.size());
        end
    endtask

`ifdef IDPSEQ_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        do_reset();
        checks++;
        if (retire_cnt !== 16'd0) begin
            errors++;
            $display("FAIL retire_reset got=%0d required=0", retire_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 4'h2});
            send(16'h2298);
        end
        @(posedge clk); #1;
        checks++;
        if (retire_cnt !== 16'd5) begin
            errors++;
            $display("FAIL retire_count got=%0d required=5", retire_cnt);
        end
        send(16'hF000);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (retire_cnt !== 16'd5) begin
            errors++;
            $display("FAIL retire_halt got=%0d required=5", retire_cnt);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_ldi();
        test_addi();
        test_flags();
        test_halt();
        test_reset_mid_op();
`ifdef IDPSEQ_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
